// File: rtl/alu_pkg.sv
// Shared definitions for the sequential 6502-style ALU.
// Op codes, FSM state encoding and a width helper.
package alu_pkg;

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_EOR = 3'd3;
    localparam logic [2:0] OP_SR  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BCD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One 4-bit digit adder with optional decimal adjust.
// raw3 is bit 3 of the sum before adjustment.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    input  logic       dec,
    output logic [3:0] sum,
    output logic       carry,
    output logic       raw3
);

    logic [4:0] s;
    logic       adj;

    always_comb begin
        s     = {1'b0, a} + {1'b0, b} + {4'b0, c};
        adj   = dec & (s > 5'd9);
        raw3  = s[3];
        sum   = adj ? s[3:0] + 4'd6 : s[3:0];
        carry = adj | s[4];
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle binary ops, nibble-serial BCD add.
// Digit 0 is added on the accept edge, so BCD latency equals NDIG.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       OP,
    input  logic             BCDS,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             OF,
    output logic             Cout,
    output logic             HCout,
    output logic             ZF,
    output logic             NF
);

    localparam int NDIG = WIDTH / 4;
    localparam int CW   = clog2(NDIG);

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("alu_seq: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t           state, nxt;
    logic             accept, start_bcd, in_bcd, last, commit_bcd;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
    logic             c_q, hc_q, a_msb, b_msb;
    logic [CW-1:0]    cnt;
    logic [3:0]       da, db, dsum;
    logic             dc, ddec, dcarry, draw3;
    logic             am, bm, dec_of;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bres;
    logic             bcout, bof, bhc;

    assign IN_READY  = !RST & ((state == ST_IDLE)
                     | ((state == ST_DONE) & OUT_READY));
    assign OUT_VALID = (state == ST_DONE);
    assign accept    = IN_VALID & IN_READY;
    assign start_bcd = BCDS & (OP == OP_SUM);
    assign in_bcd    = (state == ST_BCD);
    assign last      = in_bcd & (cnt == CW'(NDIG - 2));
    assign commit_bcd = last | (accept & start_bcd & (NDIG == 1));

    // Outside the digit loop the adder sees the live operands,
    // which also yields the binary half-carry.
    assign da   = in_bcd ? a_sh[3:0] : A[3:0];
    assign db   = in_bcd ? b_sh[3:0] : B[3:0];
    assign dc   = in_bcd ? c_q : Cin;
    assign ddec = in_bcd | start_bcd;

    bcd_digit_add u_dig (
        .a     (da),
        .b     (db),
        .c     (dc),
        .dec   (ddec),
        .sum   (dsum),
        .carry (dcarry),
        .raw3  (draw3)
    );

    assign acc_nxt = ((in_bcd ? acc : '0) >> 4)
                   | (WIDTH'(dsum) << (WIDTH - 4));
    assign am      = in_bcd ? a_msb : A[WIDTH-1];
    assign bm      = in_bcd ? b_msb : B[WIDTH-1];
    assign dec_of  = (am == bm) & (draw3 != am);

    assign full = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};

    always_comb begin
        bres  = A;
        bcout = Cin;
        bof   = 1'b0;
        bhc   = 1'b0;
        unique case (1'b1)
            (OP == OP_SUM): begin
                bres  = full[WIDTH-1:0];
                bcout = full[WIDTH];
                bhc   = dcarry;
                bof   = (A[WIDTH-1] == B[WIDTH-1])
                      & (full[WIDTH-1] != A[WIDTH-1]);
            end
            (OP == OP_AND): bres = A & B;
            (OP == OP_OR):  bres = A | B;
            (OP == OP_EOR): bres = A ^ B;
            (OP == OP_SR): begin
                bres  = {Cin, A[WIDTH-1:1]};
                bcout = A[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (accept)
                    nxt = (start_bcd && NDIG > 1) ? ST_BCD : ST_DONE;
                else if (state == ST_DONE && OUT_READY)
                    nxt = ST_IDLE;
            end
            ST_BCD:  if (last) nxt = ST_DONE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RESULT <= '0;
            OF     <= 1'b0;
            Cout   <= 1'b0;
            HCout  <= 1'b0;
            ZF     <= 1'b0;
            NF     <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            c_q    <= 1'b0;
            hc_q   <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            if (accept && start_bcd) begin
                a_sh  <= A >> 4;
                b_sh  <= B >> 4;
                a_msb <= A[WIDTH-1];
                b_msb <= B[WIDTH-1];
                c_q   <= dcarry;
                hc_q  <= dcarry;
                acc   <= acc_nxt;
                cnt   <= '0;
            end else if (accept) begin
                RESULT <= bres;
                Cout   <= bcout;
                OF     <= bof;
                HCout  <= bhc;
                ZF     <= (bres == '0);
                NF     <= bres[WIDTH-1];
            end else if (in_bcd) begin
                a_sh <= a_sh >> 4;
                b_sh <= b_sh >> 4;
                c_q  <= dcarry;
                acc  <= acc_nxt;
                cnt  <= cnt + 1'b1;
            end
            if (commit_bcd) begin
                RESULT <= acc_nxt;
                Cout   <= dcarry;
                OF     <= dec_of;
                HCout  <= in_bcd ? hc_q : dcarry;
                ZF     <= (acc_nxt == '0);
                NF     <= acc_nxt[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16.
// Expected results are queued at issue and checked at output handshake.
module tb_alu_seq;

    typedef struct {
        logic [15:0] res;
        logic        of;
        logic        cout;
        logic        hc;
        logic        zf;
        logic        nf;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic clk, rst;
    int   cyc, n_chk, n_fail;
    bit   rnd_bp;

    logic       v8, rdy8, bcd8, cin8, ov8, ordy8, of8, co8, hc8, zf8, nf8;
    logic [2:0] op8;
    logic [7:0] a8, b8, res8;

    logic        v16, rdy16, bcd16, cin16, ov16, ordy16;
    logic        of16, co16, hc16, zf16, nf16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, res16;

    exp_t q8[$], q16[$];
    exp_t e8, e16;
    bit   lat8_done, lat16_done;

    alu_seq #(.WIDTH(8)) u8 (
        .CLK(clk), .RST(rst), .IN_VALID(v8), .IN_READY(rdy8),
        .OP(op8), .BCDS(bcd8), .A(a8), .B(b8), .Cin(cin8),
        .OUT_VALID(ov8), .OUT_READY(ordy8), .RESULT(res8),
        .OF(of8), .Cout(co8), .HCout(hc8), .ZF(zf8), .NF(nf8)
    );

    alu_seq #(.WIDTH(16)) u16 (
        .CLK(clk), .RST(rst), .IN_VALID(v16), .IN_READY(rdy16),
        .OP(op16), .BCDS(bcd16), .A(a16), .B(b16), .Cin(cin16),
        .OUT_VALID(ov16), .OUT_READY(ordy16), .RESULT(res16),
        .OF(of16), .Cout(co16), .HCout(hc16), .ZF(zf16), .NF(nf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1;
            ordy8  = ($urandom % 4) != 0;
            ordy16 = ($urandom % 4) != 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic bcd, input logic [15:0] ai,
                                   input logic [15:0] bi, input logic cin);
        exp_t e;
        logic [15:0] m, a, b;
        logic [16:0] f;
        logic [4:0] s;
        logic c, top;
        m = (w == 16) ? 16'hFFFF : 16'h00FF;
        a = ai & m;
        b = bi & m;
        e.res = a; e.of = 0; e.cout = cin; e.hc = 0;
        e.lat = 1; e.acc_cyc = 0;
        case (op)
            3'd0: begin
                if (bcd) begin
                    c = cin; top = 0; e.res = '0;
                    for (int i = 0; i < w / 4; i++) begin
                        s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
                        top = s[3];
                        if (s > 5'd9) begin
                            s = s + 5'd6;
                            c = 1'b1;
                        end else c = s[4];
                        e.res[4*i +: 4] = s[3:0];
                        if (i == 0) e.hc = c;
                    end
                    e.cout = c;
                    e.of = (a[w-1] == b[w-1]) && (top != a[w-1]);
                    e.lat = w / 4;
                end else begin
                    f = {1'b0, a} + {1'b0, b} + {16'b0, cin};
                    e.res = f[15:0] & m;
                    e.cout = f[w];
                    s = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
                    e.hc = s[4];
                    e.of = (a[w-1] == b[w-1]) && (e.res[w-1] != a[w-1]);
                end
            end
            3'd1: e.res = a & b;
            3'd2: e.res = a | b;
            3'd3: e.res = a ^ b;
            3'd4: begin
                e.res = ((a >> 1) | ({15'b0, cin} << (w - 1))) & m;
                e.cout = a[0];
            end
            default: e.res = a;
        endcase
        e.zf = (e.res == 16'h0);
        e.nf = e.res[w-1];
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && ov8 && q8.size() == 0)
            chk("spurious8", ov8, 1'b0);
        else if (!rst && ov8) begin
            if (!lat8_done) begin
                chk("lat8", cyc - q8[0].acc_cyc, q8[0].lat);
                lat8_done = 1;
            end
            if (ordy8) begin
                e8 = q8.pop_front();
                chk("res8", res8, e8.res);
                chk("of8", of8, e8.of);
                chk("cout8", co8, e8.cout);
                chk("hc8", hc8, e8.hc);
                chk("zf8", zf8, e8.zf);
                chk("nf8", nf8, e8.nf);
                lat8_done = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov16 && q16.size() == 0)
            chk("spurious16", ov16, 1'b0);
        else if (!rst && ov16) begin
            if (!lat16_done) begin
                chk("lat16", cyc - q16[0].acc_cyc, q16[0].lat);
                lat16_done = 1;
            end
            if (ordy16) begin
                e16 = q16.pop_front();
                chk("res16", res16, e16.res);
                chk("of16", of16, e16.of);
                chk("cout16", co16, e16.cout);
                chk("hc16", hc16, e16.hc);
                chk("zf16", zf16, e16.zf);
                chk("nf16", nf16, e16.nf);
                lat16_done = 0;
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input bit w16, input logic [2:0] op, input logic bcd,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output int waits);
        exp_t e;
        e = model(w16 ? 16 : 8, op, bcd, a, b, cin);
        if (w16) begin
            v16 = 1; op16 = op; bcd16 = bcd; a16 = a; b16 = b; cin16 = cin;
        end else begin
            v8 = 1; op8 = op; bcd8 = bcd; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin;
        end
        waits = 0;
        #1;
        while (!(w16 ? rdy16 : rdy8) && waits < 100) begin
            @(posedge clk);
            #2;
            waits++;
        end
        if (waits >= 100) chk("accept_timeout", w16 ? rdy16 : rdy8, 1'b1);
        e.acc_cyc = cyc;
        if (w16) q16.push_back(e);
        else     q8.push_back(e);
        @(posedge clk);
        #1;
        if (w16) begin
            v16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = ~cin;
        end else begin
            v8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~cin;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain8", q8.size(), 0);
        chk("drain16", q16.size(), 0);
    endtask

    initial begin
        int w;
        exp_t bp;
        rst = 1; cyc = 0; n_chk = 0; n_fail = 0; rnd_bp = 0;
        v8 = 0; op8 = 0; bcd8 = 0; a8 = 0; b8 = 0; cin8 = 0; ordy8 = 1;
        v16 = 0; op16 = 0; bcd16 = 0; a16 = 0; b16 = 0; cin16 = 0; ordy16 = 1;
        lat8_done = 0; lat16_done = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov8", ov8, 0);
        chk("rst_res8", res8, 0);
        chk("rst_flags8", {of8, co8, hc8, zf8, nf8}, 0);
        chk("rst_rdy8", rdy8, 0);
        chk("rst_ov16", ov16, 0);
        chk("rst_res16", res16, 0);
        chk("rst_flags16", {of16, co16, hc16, zf16, nf16}, 0);
        rst = 0;
        #1;
        chk("post_rst_rdy8", rdy8, 1);
        @(posedge clk);
        #1;

        issue(0, 3'd0, 0, 16'h50, 16'h50, 0, w);
        issue(0, 3'd0, 1, 16'h58, 16'h46, 1, w);
        drain();

        ordy8 = 0;
        bp = model(8, 3'd4, 0, 16'h81, 16'h00, 1);
        issue(0, 3'd4, 0, 16'h81, 16'h00, 1, w);
        repeat (5) begin
            @(negedge clk);
            chk("bp_res", res8, bp.res);
            chk("bp_rdy", rdy8, 0);
            chk("bp_ov", ov8, 1);
        end
        @(posedge clk);
        #1;
        ordy8 = 1;
        issue(0, 3'd1, 0, 16'hF0, 16'h3C, 0, w);
        chk("no_bubble", w, 0);

        issue(0, 3'd2, 0, 16'h0F, 16'hA0, 0, w);
        issue(0, 3'd3, 0, 16'hFF, 16'h0F, 1, w);
        issue(0, 3'd6, 1, 16'h5A, 16'h33, 0, w);
        issue(0, 3'd0, 0, 16'h30, 16'hEF, 1, w);
        issue(0, 3'd0, 0, 16'hFF, 16'h01, 0, w);
        issue(0, 3'd0, 1, 16'hAF, 16'hBF, 0, w);

        issue(1, 3'd0, 1, 16'h9999, 16'h0001, 0, w);
        issue(1, 3'd0, 0, 16'h1234, 16'h1111, 0, w);
        issue(1, 3'd0, 1, 16'h4321, 16'h1234, 1, w);
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("rst_mid_rdy16", rdy16, 0);
        q16.delete();
        lat16_done = 0;
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("abort_ov16", ov16, 0);
        chk("abort_res16", res16, 0);
        chk("abort_rdy16", rdy16, 1);
        issue(1, 3'd0, 1, 16'h1234, 16'h5678, 0, w);
        drain();

        rnd_bp = 1;
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom % 2), 3'($urandom % 8), 1'($urandom % 2),
                  16'($urandom), 16'($urandom), 1'($urandom % 2), w);
        end
        rnd_bp = 0;
        @(posedge clk);
        #1;
        ordy8 = 1;
        ordy16 = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the 6502 datapath ALU, generalised to any WIDTH that is a multiple of 4.
- Binary operations (SUM, AND, OR, EOR, shift-right through carry) complete in one cycle.
- Decimal (BCD) SUM runs nibble-serially, one digit per cycle.
- Result and flags stay registered until the consumer takes them.
- Sits between the operand latches and the register file / status register, decoupled by valid/ready on both sides.

Parameters:
- WIDTH, 8, operand/result width. Must be a multiple of 4 and ≥4; any other value is an elaboration error.
- NDIG, WIDTH/4, derived localparam, BCD digit count.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  operands/op presented.
- IN_READY  out  1  block can accept.
- OP  in  3  0 SUM, 1 AND, 2 OR, 3 EOR, 4 SR, 5-7 reserved.
- BCDS  in  1  decimal mode; affects SUM only.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B. Caller pre-inverts B for subtract.
- Cin  in  1  carry in.
- OUT_VALID  out  1  result/flags valid.
- OUT_READY  in  1  consumer accepts.
- RESULT  out  WIDTH  registered result.
- OF  out  1  overflow.
- Cout  out  1  carry out.
- HCout  out  1  carry out of digit 0 (bit 3).
- ZF  out  1  RESULT==0.
- NF  out  1  RESULT[WIDTH-1].

Behaviour:
- States:
  - IDLE: accepting.
  - BCD: digit loop.
  - DONE: holding output.
- Reset, synchronous: state IDLE, OUT_VALID=0, RESULT=0, OF=Cout=HCout=ZF=NF=0, digit counter 0.
  - IN_READY=0 while RST is high.
  - Reset aborts any operation in progress; no partial result is ever presented.
- IN_READY = (state==IDLE) | (state==DONE & OUT_READY).
- Accept occurs when IN_VALID & IN_READY. A, B, OP, BCDS and Cin are captured at accept; later input changes have no effect.
- Binary ops: result and flags are registered at the accept edge, and the state moves to DONE. OUT_VALID goes high one cycle after accept (latency 1).
- BCDS=1 with OP=SUM: move to BCD with counter=0.
  - Each edge processes digit i: s = A[i]+B[i]+c; if s>9 then s=s+6 and carry=1, else carry=s[4]; the digit is s[3:0].
  - Digit 0 uses c=Cin. HCout is taken from the digit-0 carry.
  - On the edge that commits digit NDIG-1, the state moves to DONE. Latency is NDIG cycles.
- Digits above 9 are not rejected; the same rule applies and the result is truncated to 4 bits.
- SUM binary: {Cout,RESULT} = A+B+Cin. OF = (A[msb]==B[msb]) & (RESULT[msb]!=A[msb]). HCout is the carry into bit 4.
- SUM decimal: OF uses the same formula applied to the top digit's pre-adjust sum bit 3 in place of RESULT[msb]. Cout is the final digit carry.
- AND/OR/EOR: bitwise. Cout=Cin, OF=0, HCout=0.
- SR: RESULT = {Cin, A[WIDTH-1:1]}, Cout=A[0], OF=0, HCout=0.
- Reserved OP: RESULT=A, Cout=Cin, OF=0, HCout=0, latency 1.
- ZF and NF are always computed from the final RESULT, in both binary and decimal mode.
- DONE:
  - RESULT and flags stay stable while OUT_VALID & !OUT_READY.
  - On OUT_READY with no new accept, go to IDLE and drop OUT_VALID.
  - On OUT_READY with a simultaneous accept, start the next operation with no bubble.
- RST has priority over every other event in the same cycle.

Decomposition:
- Package alu_pkg holds:
  - OP code localparams (OP_SUM..OP_SR).
  - State encoding (ST_IDLE, ST_BCD, ST_DONE).
  - Function clog2 for the digit counter width, minimum 1.
- Sub-module bcd_digit_add: 4-bit digit adder.
  - Inputs: a, b, c, dec.
  - Outputs: sum[3:0], carry, raw bit 3.
  - Instantiated once; it is iterated by the digit counter.

Test Plan:
- WIDTH=8, SUM binary, A=0x50, B=0x50, Cin=0 -> after 1 cycle: RESULT=0xA0, OF=1, Cout=0, HCout=0, NF=1, ZF=0.
- WIDTH=8, SUM BCD, A=0x58, B=0x46, Cin=1 -> OUT_VALID 2 cycles after accept: RESULT=0x05, Cout=1, HCout=1, ZF=0.
- WIDTH=16, SUM BCD, A=0x9999, B=0x0001, Cin=0 -> latency 4: RESULT=0x0000, Cout=1, ZF=1.
- SR, A=0x81, Cin=1 -> RESULT=0xC0, Cout=1, NF=1.
- Backpressure: hold OUT_READY=0 for 5 cycles -> RESULT stable and IN_READY=0 throughout. Then OUT_READY=1 with IN_VALID=1 (AND, 0xF0&0x3C) -> accepted the same cycle; next result 0x30.
- WIDTH=16 BCD, assert RST for 1 cycle after 2 digits -> OUT_VALID=0 and RESULT=0; IN_READY=1 on the first cycle after RST falls, and a new op completes normally.
